// File: rtl/div16_if.sv
// div16_if: operand/result bundle between the execute stage and div16.
// master drives operands and the start request; slave is the divider.
interface div16_if;
  logic        op_start;
  logic        div_finish;
  logic [31:0] A;
  logic [15:0] B;
  logic [15:0] Q;
  logic [15:0] R;
  logic        div_zero;
  logic        ovf;

  modport master (
    output op_start, A, B,
    input  div_finish, Q, R, div_zero, ovf
  );

  modport slave (
    input  op_start, A, B,
    output div_finish, Q, R, div_zero, ovf
  );
endinterface

// File: rtl/div16.sv
// div16: sequential 32/16 unsigned restoring divider, one quotient bit per
// clock, 16 CALC cycles per operation. Results stay registered until the
// next accepted operation completes.
// Optional macro DIV16_EXC_CHECK_EN: flags divide-by-zero and quotient
// overflow on the accept edge and short-circuits those operations through
// a one-cycle exit path (Q=FFFF, R=0).
module div16 (
  input  logic    clk,
  input  logic    rst_n,
  div16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, EXC} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] rem, rem_n;
  logic [15:0] quo, quo_n;
  logic [15:0] b_r, b_n;
  logic [15:0] q_r, q_n;
  logic [15:0] r_r, r_n;
  logic        dz_r, dz_n;
  logic        ovf_r, ovf_n;
  logic        fin_r;

  // One restoring step: 17-bit partial remainder against zero-extended divisor
  logic [16:0] t;
  logic [16:0] diff;
  logic        ge;
  logic [15:0] rem_step;

  assign t        = {rem, quo[15]};
  assign diff     = t - {1'b0, b_r};
  assign ge       = (t >= {1'b0, b_r});
  assign rem_step = ge ? diff[15:0] : t[15:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      b_r   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
      ovf_r <= 1'b0;
      fin_r <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      quo   <= quo_n;
      b_r   <= b_n;
      q_r   <= q_n;
      r_r   <= r_n;
      dz_r  <= dz_n;
      ovf_r <= ovf_n;
      fin_r <= (state_n == IDLE);
    end
  end

  // Next-state and datapath update: accept in IDLE, iterate in CALC
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    quo_n   = quo;
    b_n     = b_r;
    q_n     = q_r;
    r_n     = r_r;
    dz_n    = dz_r;
    ovf_n   = ovf_r;
    case (state)
      IDLE: begin
        if (bus.op_start) begin
          b_n     = bus.B;
          rem_n   = bus.A[31:16];
          quo_n   = bus.A[15:0];
          cnt_n   = '0;
          dz_n    = 1'b0;
          ovf_n   = 1'b0;
          state_n = CALC;
`ifdef DIV16_EXC_CHECK_EN
          dz_n  = (bus.B == '0);
          ovf_n = (bus.B != '0) && (bus.A[31:16] >= bus.B);
          if (dz_n || ovf_n) state_n = EXC;
`endif
        end
      end
      CALC: begin
        rem_n = rem_step;
        quo_n = {quo[14:0], ge};
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd15) begin
          q_n     = {quo[14:0], ge};
          r_n     = rem_step;
          state_n = IDLE;
        end
      end
      EXC: begin
        q_n     = '1;
        r_n     = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.div_finish = fin_r;
  assign bus.Q          = q_r;
  assign bus.R          = r_r;
  assign bus.div_zero   = dz_r;
  assign bus.ovf        = ovf_r;

endmodule

// File: doc/div16.md
# div16

Sequential 32-by-16 unsigned divider, the inverse arithmetic unit to the team's 16x16 multiplier, using the same op_start/finish handshake. It sits beside the multiplier in the COMMON execute path and serves the DIV/MOD instructions. It computes a 16-bit quotient and a 16-bit remainder with a restoring radix-2 algorithm, one quotient bit per clock. Results stay registered until the next accepted operation.

## Interface
Parameters:
- none (widths fixed: 32-bit dividend, 16-bit divisor, quotient and remainder)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_start  in  1  start request; sampled only while idle
- div_finish  out  1  1 = idle with results valid, 0 = busy; registered
- A  in  32  dividend, unsigned; sampled on the accepting edge only
- B  in  16  divisor, unsigned; sampled on the accepting edge only
- Q  out  16  quotient, registered
- R  out  16  remainder, registered
- div_zero  out  1  B was 0 for the last accepted operation (see Configuration)
- ovf  out  1  quotient would exceed 16 bits: B != 0 and A[31:16] >= B (see Configuration)

## Operation
- States: IDLE, CALC.
- IDLE: div_finish=1. If op_start=1, latch A and B, clear div_zero/ovf, load rem=A[31:16], quo=A[15:0], cnt=0, and go to CALC.
- CALC, per cycle: t={rem,quo[15]} (17 bits). If t >= {1'b0,B}, rem=t-B (low 16 bits) and bit=1; else rem=t[15:0] and bit=0. Then quo={quo[14:0],bit} and cnt=cnt+1. When cnt=15 (16th step), go to IDLE.
- Q=quo and R=rem. Q and R are updated only when CALC completes. They hold through IDLE and through the next operation until that operation completes.
- op_start while in CALC is ignored. It is not queued, and operands are not re-sampled.
- Subtraction width is 17 bits, so the compare never overflows for any B when A[31:16] < B.
- Valid results satisfy A = Q*B + R with R < B.

## Timing
- Reset (async assert, any state): state=IDLE, cnt=0, div_finish=1, Q=16'h0000, R=16'h0000, div_zero=0, ovf=0.
- Reset deassertion mid-operation: the block restarts in IDLE. The aborted operation produces no result.
- Accept edge N (IDLE, op_start=1): div_finish=0 from after edge N.
- Normal latency: 16 CALC cycles. div_finish returns to 1 after edge N+16, with Q/R valid in the same cycle.
- op_start held high continuously starts a new operation on the first IDLE edge. div_finish is therefore 1 for exactly one cycle between back-to-back operations.
- No combinational path from inputs to outputs.

## Configuration
- DIV16_EXC_CHECK_EN defined:
  - On the accept edge, div_zero=(B==0) and ovf=(B!=0 && A[31:16]>=B).
  - If either flag is set, the block skips CALC: it enters a one-cycle exit path, then returns to IDLE with Q=16'hFFFF and R=16'h0000. div_finish is 0 for exactly 1 cycle.
  - Flags hold until the next accept edge.
- DIV16_EXC_CHECK_EN undefined:
  - div_zero and ovf are constant 0.
  - Every operation takes 16 CALC cycles.
  - Q/R for B==0 or A[31:16]>=B are unspecified and must not be checked.

## Test plan
- Reset: assert rst_n=0 mid-CALC -> div_finish=1, Q=0, R=0, flags 0 immediately. Release, then start 100/10 -> Q=10, R=0 after 16 cycles.
- Normal: A=32'd100000, B=16'd7 -> div_finish low exactly 16 cycles, then Q=16'd14285, R=16'd5.
- Extremes: A=32'hFFFE0001, B=16'hFFFF -> Q=16'hFFFF, R=0. A=32'h0000FFFF, B=1 -> Q=16'hFFFF, R=0. A=5, B=16'hFFFF -> Q=0, R=5.
- Handshake: pulse op_start on cycles 3-10 of a running operation with different A/B -> ignored, and the original result is correct. op_start held high -> back-to-back operations with one-cycle div_finish=1 gaps, and Q/R update each time.
- Exceptions (macro defined): B=0, A=123 -> div_zero=1, ovf=0, Q=16'hFFFF, R=0, 1-cycle busy. A=32'h00010000, B=1 -> ovf=1, div_zero=0, same result and latency.
- Exceptions (macro undefined): B=0 -> flags stay 0, busy exactly 16 cycles, Q/R not checked.
